// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage HI/LO unit. Holds the HI and LO registers,
// runs MULT/MULTU/DIV/DIVU on a shared 32-iteration shift datapath and
// handles MTHI/MTLO moves.
// Optional build macro: HILO_FAST_MUL_EN selects a single-cycle array
// multiply that writes HI/LO in the issue cycle; divide stays iterative.
module hilo_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  hi_mdr,
   input  logic        hi_write,
   input  logic        lo_write,
   input  logic        is_signed,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic [31:0] acc_hi_reg, acc_lo_reg, opnd_reg, raw_a_reg;
   logic        op_div_reg, neg_hi_reg, neg_lo_reg, div_zero_reg;
   logic [31:0] hi_reg, lo_reg;

   // Decode of the control fields presented by the instruction in E.
   logic start, start_iter, mthi, mtlo, idle_ok;
   assign start   = (hi_mdr == 2'b01 || hi_mdr == 2'b10) && hi_write && lo_write;
   assign mthi    = (hi_mdr == 2'b11) && hi_write;
   assign mtlo    = lo_write && !hi_write;
   assign idle_ok = (state_reg == IDLE) && !flush;

`ifdef HILO_FAST_MUL_EN
   logic        start_mul;
   logic [63:0] ext_a, ext_b, fast_prod;
   assign start_mul  = start && (hi_mdr == 2'b01);
   assign start_iter = start && (hi_mdr == 2'b10);
   assign ext_a      = {(is_signed ? {32{src_a[31]}} : 32'd0), src_a};
   assign ext_b      = {(is_signed ? {32{src_b[31]}} : 32'd0), src_b};
   // Low 64 bits of the extended product are correct for both signednesses.
   assign fast_prod  = ext_a * ext_b;
`else
   assign start_iter = start;
`endif

   // Operand magnitudes; 0x80000000 negates to itself, which is the
   // correct unsigned magnitude.
   logic        sign_a, sign_b;
   logic [31:0] abs_a, abs_b;
   assign sign_a = is_signed && src_a[31];
   assign sign_b = is_signed && src_b[31];
   assign abs_a  = sign_a ? -src_a : src_a;
   assign abs_b  = sign_b ? -src_b : src_b;

   // One iteration of each algorithm. acc_lo holds dividend/multiplier
   // bits being shifted out; acc_hi holds partial remainder/product.
   logic [32:0] div_shift, div_diff, mul_sum;
   logic        div_ge;
   logic [31:0] iter_hi, iter_lo;
   assign div_shift = {acc_hi_reg, acc_lo_reg[31]};
   assign div_diff  = div_shift - {1'b0, opnd_reg};
   assign div_ge    = !div_diff[32];
   assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
   assign iter_hi   = op_div_reg ? (div_ge ? div_diff[31:0] : div_shift[31:0]) : mul_sum[32:1];
   assign iter_lo   = op_div_reg ? {acc_lo_reg[30:0], div_ge} : {mul_sum[0], acc_lo_reg[31:1]};

   // Sign correction and divide-by-zero override applied in DONE.
   logic [63:0] prod_fix;
   logic [31:0] res_hi, res_lo;
   assign prod_fix = neg_lo_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
   always_comb begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
      if (op_div_reg) begin
         if (div_zero_reg) begin
            res_hi = raw_a_reg;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = neg_hi_reg ? -acc_hi_reg : acc_hi_reg;
            res_lo = neg_lo_reg ? -acc_lo_reg : acc_lo_reg;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic; flush aborts from any state.
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start_iter) state_next = RUN;
            RUN:     if (count_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Stall/busy outputs; stall is combinational on the issue cycle only.
   always_comb begin
      stall = 1'b0;
      busy  = (state_reg != IDLE);
      case (state_reg)
         IDLE:    stall = start_iter && !flush;
         RUN:     stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   // Iterative datapath: capture operands on issue, iterate in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg    <= 5'd0;
         acc_hi_reg   <= 32'd0;
         acc_lo_reg   <= 32'd0;
         opnd_reg     <= 32'd0;
         raw_a_reg    <= 32'd0;
         op_div_reg   <= 1'b0;
         neg_hi_reg   <= 1'b0;
         neg_lo_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
      end else if (idle_ok && start_iter) begin
         count_reg    <= 5'd0;
         acc_hi_reg   <= 32'd0;
         acc_lo_reg   <= abs_a;
         opnd_reg     <= abs_b;
         raw_a_reg    <= src_a;
         op_div_reg   <= (hi_mdr == 2'b10);
         neg_hi_reg   <= sign_a;
         neg_lo_reg   <= sign_a ^ sign_b;
         div_zero_reg <= (src_b == 32'd0);
      end else if (state_reg == RUN && !flush) begin
         count_reg    <= count_reg + 5'd1;
         acc_hi_reg   <= iter_hi;
         acc_lo_reg   <= iter_lo;
      end
   end

   // Architectural HI/LO: result commit in DONE, moves (and fast multiply) in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_reg <= 32'd0;
         lo_reg <= 32'd0;
      end else if (state_reg == DONE && !flush) begin
         hi_reg <= res_hi;
         lo_reg <= res_lo;
      end else if (idle_ok) begin
`ifdef HILO_FAST_MUL_EN
         if (start_mul) begin
            hi_reg <= fast_prod[63:32];
            lo_reg <= fast_prod[31:0];
         end else
`endif
         if (mthi)      hi_reg <= src_a;
         else if (mtlo) lo_reg <= src_a;
      end
   end

   assign hi_o = hi_reg;
   assign lo_o = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: the driver pushes expected HI/LO and
// stall-cycle counts, the monitor pops and compares when a transaction ends.
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  hi_mdr = 2'b00;
   logic        hi_write = 1'b0, lo_write = 1'b0, is_signed = 1'b0, flush = 1'b0;
   logic [31:0] src_a = 32'd0, src_b = 32'd0;
   logic        stall, busy;
   logic [31:0] hi_o, lo_o;
   logic        txn_done = 1'b0;

   int total = 0;
   int bad   = 0;
   int stall_cnt = 0;

`ifdef HILO_FAST_MUL_EN
   localparam int MUL_ST = 0;
`else
   localparam int MUL_ST = 33;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          st;
      string       name;
   } exp_t;
   exp_t sb[$];

   hilo_muldiv dut (
      .clk(clk), .rst(rst), .hi_mdr(hi_mdr), .hi_write(hi_write),
      .lo_write(lo_write), .is_signed(is_signed), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stall(stall), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   // Monitor: counts stall-high cycles and checks each completed transaction.
   always @(negedge clk) begin
      #2;
      if (stall) stall_cnt++;
      if (txn_done) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: transaction completed with nothing expected");
         end else begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (hi_o !== e.hi) begin bad++; $display("FAIL %s.hi: got %08h want %08h", e.name, hi_o, e.hi); end
            total++;
            if (lo_o !== e.lo) begin bad++; $display("FAIL %s.lo: got %08h want %08h", e.name, lo_o, e.lo); end
            total++;
            if (stall_cnt != e.st) begin bad++; $display("FAIL %s.stall_cycles: got %0d want %0d", e.name, stall_cnt, e.st); end
            total++;
            if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL %s.idle: busy=%b stall=%b want 0 0", e.name, busy, stall); end
            $display("txn %-10s hi=%08h lo=%08h stall_cycles=%0d", e.name, hi_o, lo_o, stall_cnt);
         end
         stall_cnt = 0;
      end
   end

   task automatic set_nop();
      hi_mdr = 2'b00; hi_write = 1'b0; lo_write = 1'b0; is_signed = 1'b0;
      src_a = 32'd0; src_b = 32'd0;
   endtask

   task automatic finish_txn();
      @(negedge clk);
      set_nop();
      txn_done = 1'b1;
      @(negedge clk);
      txn_done = 1'b0;
   endtask

   // Present an instruction and hold it while stall is high, like the pipeline.
   task automatic issue(input string name, input logic [1:0] mdr, input logic hw, input logic lw,
                        input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int est);
      int n;
      sb.push_back('{ehi, elo, est, name});
      @(negedge clk);
      hi_mdr = mdr; hi_write = hw; lo_write = lw; is_signed = sg; src_a = a; src_b = b;
      #1;
      n = 0;
      while (stall && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL %s.timeout: stall still high after %0d cycles", name, n);
      end
      finish_txn();
   endtask

   // Start a DIV then hit it with flush or reset during cycle 10.
   task automatic abort_div(input string name, input logic use_rst,
                            input logic [31:0] ehi, input logic [31:0] elo);
      sb.push_back('{ehi, elo, 11, name});
      @(negedge clk);
      hi_mdr = 2'b10; hi_write = 1'b1; lo_write = 1'b1; is_signed = 1'b1;
      src_a = 32'd1000; src_b = 32'd7;
      repeat (10) @(negedge clk);
      if (use_rst) rst = 1'b1; else flush = 1'b1;
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      set_nop();
      txn_done = 1'b1;
      @(negedge clk);
      txn_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      sb.push_back('{32'd0, 32'd0, 0, "reset"});
      repeat (3) @(negedge clk);
      rst = 1'b0;
      txn_done = 1'b1;
      @(negedge clk);
      txn_done = 1'b0;

      //    name          mdr    hw    lw    sg    src_a         src_b         exp hi        exp lo        stall
      issue("mthi",      2'b11, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0);
      issue("mtlo",      2'b00, 1'b0, 1'b1, 1'b0, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0);
      issue("div_m7_2",  2'b10, 1'b1, 1'b1, 1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      issue("divu_big",  2'b10, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33);
      issue("div_by0",   2'b10, 1'b1, 1'b1, 1'b1, 32'h00000055, 32'h0,        32'h00000055, 32'hFFFFFFFF, 33);
      issue("div_ovf",   2'b10, 1'b1, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
      issue("divu_by0",  2'b10, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 33);
      issue("div_7_m2",  2'b10, 1'b1, 1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
      issue("mult_m1x2", 2'b01, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, MUL_ST);
      issue("multu_big", 2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, MUL_ST);
      issue("mult_m3m5", 2'b01, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, MUL_ST);
      issue("mult_min2", 2'b01, 1'b1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_ST);
      abort_div("flush_div", 1'b0, 32'h40000000, 32'h00000000);
      abort_div("rst_div",   1'b1, 32'h00000000, 32'h00000000);

      repeat (2) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d expected transactions never completed, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
